// File: rtl/usr_frame_tx.sv
// Framed serial transmitter: start bit, SIZE data bits (LSB- or MSB-first),
// optional even parity, stop bit, each bit held DIV clocks.
module usr_frame_tx #(
  parameter int SIZE = 4,
  parameter int DIV  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] data_in,
  input  logic            dir,
  input  logic            parity_en,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [SIZE-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic            dir_q, dir_d;
  logic            pen_q, pen_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tick;
  logic [SIZE-1:0] shifted;
  logic            first_bit, next_bit;

  assign load_ready = (state_q == S_IDLE);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // tx is registered, so each transition loads the value of the bit that
  // the next state will present.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    dir_d     = dir_q;
    pen_d     = pen_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
    shifted   = dir_q ? {shreg_q[SIZE-2:0], 1'b0} : {1'b0, shreg_q[SIZE-1:1]};
    first_bit = dir_q ? shreg_q[SIZE-1] : shreg_q[0];
    next_bit  = dir_q ? shifted[SIZE-1] : shifted[0];

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        tx_d  = 1'b1;
        if (load_valid) begin
          state_d = S_START;
          shreg_d = data_in;
          dir_d   = dir;
          pen_d   = parity_en;
          par_d   = ^data_in;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = first_bit;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
            tx_d    = pen_q ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shifted;
            tx_d    = next_bit;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        div_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      dir_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
